// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, bus widths, requester ID.
// No ports; imported by sram_arb_beat_counter and sram_arbiter.
package sram_arb_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_READ  = 2'd1,
      D_READ  = 2'd2,
      D_WRITE = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/sram_arb_beat_counter.sv
// Wait-state and word counters for one line burst.
// Ports: clk, rst, clear (restart at word 0), run (burst active),
//        wc (current word), slot_last, line_last strobes.
module sram_arb_beat_counter
   import sram_arb_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int WORD_WAIT  = 1,
   localparam int WB = $clog2(LINE_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          run,
   output logic [WB-1:0] wc,
   output logic          slot_last,
   output logic          line_last
);

   logic [2:0] wt;

   assign slot_last = run && (wt == 3'(WORD_WAIT));
   assign line_last = slot_last && (wc == WB'(LINE_WORDS - 1));

   // wc wraps inside the line; the base address never sees a carry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wt <= '0;
         wc <= '0;
      end else if (clear) begin
         wt <= '0;
         wc <= '0;
      end else if (run) begin
         if (slot_last) begin
            wt <= '0;
            wc <= wc + 1'b1;
         end else begin
            wt <= wt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the SRAM controller port between I-cache and D-cache line bursts.
// Ports: i_* (I read), d_* (D read/write), sram_* (controller side).
// Option: SRAM_ARB_ROUND_ROBIN_EN selects round-robin on ties, else D wins.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int WORD_WAIT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_req,
   input  logic [SRAM_AW-1:0] i_addr,
   output logic [SRAM_DW-1:0] i_rdata,
   output logic               i_rvalid,
   output logic               i_done,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [SRAM_AW-1:0] d_addr,
   input  logic [SRAM_DW-1:0] d_wdata,
   output logic               d_wnext,
   output logic [SRAM_DW-1:0] d_rdata,
   output logic               d_rvalid,
   output logic               d_done,
   output logic [SRAM_AW-1:0] sram_address,
   output logic [SRAM_DW-1:0] sram_write_data,
   output logic               sram_we,
   input  logic [SRAM_DW-1:0] sram_read_data
);

   localparam int WB = $clog2(LINE_WORDS);

   arb_state_t        state;
   logic [WB-1:0]     wc;
   logic              slot_last;
   logic              line_last;
   logic              busy;
   logic              i_ok;
   logic              d_ok;
   logic              grant;
   req_id_t           pick;
   logic [SRAM_DW-1:0] wdata_q;
   logic              unused_low;

   assign unused_low = ^{i_addr[WB-1:0], d_addr[WB-1:0]};

   assign busy = (state != IDLE);

   // A requester whose done is pulsing still holds req this cycle;
   // do not mistake that for a fresh request.
   assign i_ok  = i_req && !i_done;
   assign d_ok  = d_req && !d_done;
   assign grant = i_ok || d_ok;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   req_id_t last_grant;

   always_comb begin
      pick = REQ_D;
      if (i_ok && (!d_ok || last_grant == REQ_D))
         pick = REQ_I;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= REQ_D;
      else if (state == IDLE && grant)
         last_grant <= pick;
   end
`else
   always_comb begin
      pick = d_ok ? REQ_D : REQ_I;
   end
`endif

   sram_arb_beat_counter #(
      .LINE_WORDS(LINE_WORDS),
      .WORD_WAIT (WORD_WAIT)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (!busy),
      .run      (busy),
      .wc       (wc),
      .slot_last(slot_last),
      .line_last(line_last)
   );

   // The requester advances d_wdata on d_wnext, so the bus follows it live
   assign sram_write_data = (state == D_WRITE) ? d_wdata : wdata_q;
   assign d_wnext = (state == D_WRITE) && slot_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sram_address <= '0;
         sram_we      <= 1'b0;
         wdata_q      <= '0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         i_rvalid     <= 1'b0;
         d_rvalid     <= 1'b0;
         i_done       <= 1'b0;
         d_done       <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_done   <= 1'b0;
         d_done   <= 1'b0;
         if (state == D_WRITE)
            wdata_q <= d_wdata;
         unique case (state)
            IDLE: begin
               if (grant) begin
                  if (pick == REQ_D) begin
                     sram_address <= {d_addr[SRAM_AW-1:WB], {WB{1'b0}}};
                     sram_we      <= d_we;
                     state        <= d_we ? D_WRITE : D_READ;
                  end else begin
                     sram_address <= {i_addr[SRAM_AW-1:WB], {WB{1'b0}}};
                     state        <= I_READ;
                  end
               end
            end
            I_READ, D_READ, D_WRITE: begin
               if (slot_last) begin
                  if (state == I_READ) begin
                     i_rdata  <= sram_read_data;
                     i_rvalid <= 1'b1;
                  end
                  if (state == D_READ) begin
                     d_rdata  <= sram_read_data;
                     d_rvalid <= 1'b1;
                  end
                  if (line_last) begin
                     state   <= IDLE;
                     sram_we <= 1'b0;
                     i_done  <= (state == I_READ);
                     d_done  <= (state != I_READ);
                  end else begin
                     sram_address[WB-1:0] <= wc + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
